// File: rtl/inst_feeder.sv
// Instruction feeder: plays a small program buffer into a CPU fetch port,
// with optional NOP bubbles between words, looping, stall hold and abort.
module inst_feeder #(
    parameter int          DEPTH    = 16,
    parameter int          GAP      = 0,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          loop,
    input  logic          stop,
    input  logic          stall,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [AW-1:0] pc_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUBBLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [2:0]  GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    logic [31:0]   mem_r [DEPTH];
    state_t        state_r, state_s;
    logic [AW:0]   len_r, len_s, len_clamp_s;
    logic          loop_r, loop_s;
    logic [2:0]    bub_r, bub_s;
    logic [31:0]   inst_s;
    logic          valid_s, busy_s, done_s;
    logic [AW-1:0] pc_s, nidx_s;
    logic          last_s, to_done_s, issue_next_s;

    // Program buffer write port; only open while no run is in flight.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst && load_we && (state_r == IDLE || state_r == DONE)) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Clamped length, last-word detect and wrapping next index.
    always_comb begin
        len_clamp_s = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
        last_s      = ({1'b0, pc_idx} == (len_r - (AW+1)'(1)));
        if (last_s) begin
            nidx_s = '0;
        end else begin
            nidx_s = pc_idx + AW'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        loop_s       = loop_r;
        bub_s        = bub_r;
        inst_s       = inst;
        valid_s      = inst_valid;
        pc_s         = pc_idx;
        busy_s       = busy;
        done_s       = 1'b0;
        to_done_s    = 1'b0;
        issue_next_s = 1'b0;

        case (state_r)
            IDLE: begin
                inst_s  = NOP_INST;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                if (start) begin
                    len_s  = len_clamp_s;
                    loop_s = loop;
                    bub_s  = 3'd0;
                    if (len_clamp_s == (AW+1)'(0)) begin
                        to_done_s = 1'b1;
                    end else begin
                        state_s = ISSUE;
                        inst_s  = mem_r[0];
                        valid_s = 1'b1;
                        pc_s    = '0;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // stop beats stall; stall freezes everything by keeping defaults
                if (stop) begin
                    to_done_s = 1'b1;
                end else if (stall) begin
                    state_s = ISSUE;
                end else if (GAP > 0) begin
                    state_s = BUBBLE;
                    bub_s   = 3'd0;
                    inst_s  = NOP_INST;
                    valid_s = 1'b0;
                end else if (last_s && !loop_r) begin
                    to_done_s = 1'b1;
                end else begin
                    issue_next_s = 1'b1;
                end
            end
            BUBBLE: begin
                if (stop) begin
                    to_done_s = 1'b1;
                end else if (stall) begin
                    state_s = BUBBLE;
                end else if (bub_r == GAP_LAST) begin
                    if (last_s && !loop_r) begin
                        to_done_s = 1'b1;
                    end else begin
                        issue_next_s = 1'b1;
                    end
                end else begin
                    bub_s = bub_r + 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                inst_s  = NOP_INST;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                inst_s  = NOP_INST;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        if (to_done_s) begin
            state_s = DONE;
            inst_s  = NOP_INST;
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            bub_s   = 3'd0;
        end else if (issue_next_s) begin
            state_s = ISSUE;
            inst_s  = mem_r[nidx_s];
            valid_s = 1'b1;
            pc_s    = nidx_s;
            busy_s  = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_r    <= IDLE;
            len_r      <= '0;
            loop_r     <= 1'b0;
            bub_r      <= 3'd0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            pc_idx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            loop_r     <= loop_s;
            bub_r      <= bub_s;
            inst       <= inst_s;
            inst_valid <= valid_s;
            pc_idx     <= pc_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

endmodule
